// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// stream framing constants and small state-decode helpers.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 8 * LEN_BYTES;

  // States in which a new load may be started
  function automatic logic is_rest_state(input loader_state_t s);
    logic r;
    case (s)
      ST_IDLE, ST_DONE, ST_ERR: r = 1'b1;
      default:                  r = 1'b0;
    endcase
    return r;
  endfunction

  // States in which the byte link is allowed to hand over a byte
  function automatic logic state_takes_bytes(input loader_state_t s);
    logic r;
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA: r = 1'b1;
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs stream bytes MSB-first into a big-endian word. The first three bytes
// are held in a shift register; the fourth byte is merged combinationally so
// the complete word is available in the same cycle it is accepted.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr,
  input  logic            shift_en,
  input  logic [7:0]      in_byte,
  output logic [size-1:0] word,
  output logic            word_full
);

  logic [size-9:0] shift_r;
  logic [1:0]      byte_idx_r;

  // Byte shift register and position within the current word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r    <= '0;
      byte_idx_r <= 2'd0;
    end else if (clr) begin
      shift_r    <= '0;
      byte_idx_r <= 2'd0;
    end else if (shift_en) begin
      shift_r    <= {shift_r[size-17:0], in_byte};
      byte_idx_r <= byte_idx_r + 2'd1;
    end else begin
      shift_r    <= shift_r;
      byte_idx_r <= byte_idx_r;
    end
  end

  assign word      = {shift_r, in_byte};
  assign word_full = shift_en && (byte_idx_r == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads an instruction image from a byte stream into IMem port A.
// Stream format: 16-bit big-endian word count N, then N big-endian words.
// The core is held (cpu_hold) until the whole image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int size    = 32,
  parameter int MemSize = 512,
  parameter int AddrW   = 9
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [7:0]      in_byte,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            wea,
  output logic [size-1:0] addra,
  output logic [size-1:0] dina,
  output logic            cpu_hold,
  output logic            done,
  output logic            error
);

  loader_state_t    state_r, next_state_s;
  logic [LEN_W-1:0] len_r;
  logic [AddrW:0]   word_cnt_r;   // one spare bit so N == MemSize does not wrap
  logic [AddrW:0]   cnt_inc_s;
  logic [LEN_W-1:0] len_full_s;
  logic             accept_s;
  logic             start_ok_s;
  logic             last_word_s;
  logic [size-1:0]  word_s;
  logic             word_full_s;

  assign accept_s    = in_valid & in_ready;
  assign start_ok_s  = start & is_rest_state(state_r);
  assign len_full_s  = {len_r[LEN_W-1:8], in_byte};
  assign cnt_inc_s   = word_cnt_r + {{AddrW{1'b0}}, 1'b1};
  assign last_word_s = ({{(LEN_W-AddrW-1){1'b0}}, cnt_inc_s} == len_r);

  imem_word_packer #(.size(size)) u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (start_ok_s),
    .shift_en  (accept_s && (state_r == ST_DATA)),
    .in_byte   (in_byte),
    .word      (word_s),
    .word_full (word_full_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= next_state_s;
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) next_state_s = ST_LEN_HI;
        else       next_state_s = state_r;
      end
      ST_LEN_HI: begin
        if (accept_s) next_state_s = ST_LEN_LO;
        else          next_state_s = state_r;
      end
      ST_LEN_LO: begin
        if (!accept_s)                              next_state_s = state_r;
        else if (len_full_s == {LEN_W{1'b0}})       next_state_s = ST_DONE;
        else if (len_full_s > LEN_W'(MemSize))      next_state_s = ST_ERR;
        else                                        next_state_s = ST_DATA;
      end
      ST_DATA: begin
        if (word_full_s) next_state_s = ST_WRITE;
        else             next_state_s = state_r;
      end
      ST_WRITE: begin
        if (last_word_s) next_state_s = ST_DONE;
        else             next_state_s = ST_DATA;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Word count capture and written-word counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_r      <= '0;
      word_cnt_r <= '0;
    end else if (start_ok_s) begin
      len_r      <= '0;
      word_cnt_r <= '0;
    end else begin
      if (accept_s && (state_r == ST_LEN_HI))      len_r[LEN_W-1:8] <= in_byte;
      else if (accept_s && (state_r == ST_LEN_LO)) len_r[7:0]       <= in_byte;
      else                                         len_r            <= len_r;
      if (state_r == ST_WRITE) word_cnt_r <= cnt_inc_s;
      else                     word_cnt_r <= word_cnt_r;
    end
  end

  // Registered outputs decoded from the upcoming state; address/data are
  // captured together with the fourth byte so they line up with wea
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready <= 1'b0;
      wea      <= 1'b0;
      addra    <= '0;
      dina     <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      in_ready <= state_takes_bytes(next_state_s);
      wea      <= (next_state_s == ST_WRITE);
      cpu_hold <= (next_state_s != ST_DONE);
      done     <= (next_state_s == ST_DONE);
      error    <= (next_state_s == ST_ERR);
      if (word_full_s) begin
        addra <= {{(size-AddrW){1'b0}}, word_cnt_r[AddrW-1:0]};
        dina  <= word_s;
      end else begin
        addra <= addra;
        dina  <= dina;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed/randomized bench for imem_loader. Expected IMem writes are derived
// from the word count and the image array: words 0..N-1 at addresses 0..N-1
// when 1 <= N <= 512, nothing otherwise.
module tb_imem_loader;

  localparam int MEM = 512;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, wea, cpu_hold, done, error;
  logic [31:0] addra, dina;

  imem_loader #(.size(32), .MemSize(MEM), .AddrW(9)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready), .wea(wea), .addra(addra),
    .dina(dina), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          gaps = 1'b0;
  logic [31:0] img [0:MEM-1];
  int          obs_addr [$];
  logic [31:0] obs_data [$];

  // write monitor: every wea cycle is one IMem write
  always @(negedge clk) begin
    if (wea === 1'b1) begin
      obs_addr.push_back(int'(addra));
      obs_data.push_back(dina);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_wea", wea, 1'b0);
    chk("rst_addra", addra, 32'h0);
    chk("rst_dina", dina, 32'h0);
    chk1("rst_cpu_hold", cpu_hold, 1'b1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
  endtask

  // offer one byte until accepted (bounded); returns at posedge+1 after accept
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   cyc;
    acc = 1'b0;
    cyc = 0;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    in_byte  = b;
    in_valid = 1'b1;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!acc) chk1("accept_bound", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) img[i] = $urandom();
  endtask

  task automatic begin_load(input int n);
    obs_addr.delete();
    obs_data.delete();
    pulse_start();
    chk1("start_in_ready", in_ready, 1'b1);
    chk1("start_cpu_hold", cpu_hold, 1'b1);
    chk1("start_done_clr", done, 1'b0);
    chk1("start_error_clr", error, 1'b0);
    send_byte(8'(n >> 8));
    send_byte(8'(n));
    if (n == 0) begin
      chk1("n0_done", done, 1'b1);
      chk1("n0_cpu_hold", cpu_hold, 1'b0);
    end else if (n > MEM) begin
      chk1("big_error", error, 1'b1);
      chk1("big_cpu_hold", cpu_hold, 1'b1);
      chk1("big_in_ready", in_ready, 1'b0);
    end else begin
      chk1("len_in_ready", in_ready, 1'b1);
      chk1("len_done", done, 1'b0);
    end
  endtask

  // send word i starting at byte position k_first (3 = MSB), then check the write
  task automatic send_word_from(input int i, input int k_first);
    for (int k = k_first; k >= 0; k--) send_byte(img[i][8*k +: 8]);
    chk1("wea_pulse", wea, 1'b1);
    chk("addra", addra, 32'(i));
    chk("dina", dina, img[i]);
    chk1("write_in_ready", in_ready, 1'b0);
  endtask

  task automatic send_word(input int i);
    send_word_from(i, 3);
  endtask

  task automatic finish_load(input int n);
    int exp_n;
    exp_n = (n >= 1 && n <= MEM) ? n : 0;
    if (exp_n > 0) begin
      tick();
      chk1("end_done", done, 1'b1);
      chk1("end_cpu_hold", cpu_hold, 1'b0);
      chk1("end_wea", wea, 1'b0);
    end
    repeat (3) tick();
    chk("wr_count", 32'(obs_addr.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < obs_addr.size(); i++) begin
      chk("wr_addr", 32'(obs_addr[i]), 32'(i));
      chk("wr_data", obs_data[i], img[i]);
    end
    chk1("final_done", done, 1'(n <= MEM));
    chk1("final_error", error, 1'(n > MEM));
    chk1("final_cpu_hold", cpu_hold, 1'(n > MEM));
    chk1("final_in_ready", in_ready, 1'b0);
  endtask

  task automatic run_load(input int n);
    begin_load(n);
    if (n <= MEM) for (int i = 0; i < n; i++) send_word(i);
    finish_load(n);
  endtask

  initial begin
    // reset state
    reset_n = 1'b0;
    repeat (2) tick();
    check_reset_vals();
    reset_n = 1'b1;
    tick();
    check_reset_vals();

    // bytes offered while idle are not consumed
    in_byte  = 8'hA5;
    in_valid = 1'b1;
    repeat (3) begin
      tick();
      chk1("idle_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;

    // three known words
    img[0] = 32'h8C200004;
    img[1] = 32'h00000000;
    img[2] = 32'hFFFFFFFF;
    run_load(3);

    // empty image
    run_load(0);

    // oversize count is rejected, then a valid load clears the error
    run_load(513);
    fill_random(1);
    run_load(1);

    // full memory with random stalls
    gaps = 1'b1;
    fill_random(MEM);
    run_load(MEM);
    gaps = 1'b0;

    // reset in the middle of a load
    fill_random(4);
    begin_load(4);
    send_word(0);
    send_byte(img[1][31:24]);
    send_byte(img[1][23:16]);
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    tick();
    reset_n = 1'b1;
    obs_addr.delete();
    obs_data.delete();
    in_byte  = 8'h3C;
    in_valid = 1'b1;
    repeat (4) begin
      tick();
      chk1("post_rst_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    chk("post_rst_writes", 32'(obs_addr.size()), 32'd0);
    chk1("post_rst_done", done, 1'b0);
    chk1("post_rst_cpu_hold", cpu_hold, 1'b1);
    fill_random(2);
    run_load(2);

    // start during DATA is ignored
    fill_random(3);
    begin_load(3);
    send_word(0);
    send_byte(img[1][31:24]);
    pulse_start();
    chk1("busy_start_in_ready", in_ready, 1'b1);
    chk1("busy_start_cpu_hold", cpu_hold, 1'b1);
    send_word_from(1, 2);
    send_word(2);
    finish_load(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
